// File: rtl/byte_data_memory.sv
// -----------------------------------------------------------------------------
// byte_data_memory
//
// Byte-addressable data memory with a fixed access latency and a one-cycle
// completion handshake. A request is taken only when the controller is IDLE.
// It is decoded for legality and then held for WAIT_STATES cycles. It
// completes in DONE, where Ready pulses for one cycle. Writes touch only the
// addressed byte lanes, little-endian. Loads are extracted per lane and then
// sign- or zero-extended into a registered ReadData.
//
// Parameters
//   DATA_WIDTH    word width in bits (sub-word access assumes 32)
//   MEMORY_DEPTH  number of words stored
//   WAIT_STATES   extra cycles per legal access, 0..7
//   BASE_ADDRESS  byte address of word 0
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   reset      asynchronous, active-low
//   Address    byte address of the request
//   WriteData  store data, right-aligned for byte/half stores
//   MemWrite   write request strobe
//   MemRead    read request strobe
//   Size       00 byte, 01 half, 10 word, 11 illegal
//   Unsigned   1 zero-extends, 0 sign-extends sub-word loads
//   ReadData   registered result of the last legal load
//   Ready      one-cycle completion pulse
//   AddrError  request was illegal; meaningful only while Ready=1
// -----------------------------------------------------------------------------
module byte_data_memory #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 1024,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Ready,
    output logic                  AddrError
);

    localparam int unsigned IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    // Byte span of the array, one bit wider than an address so that a large
    // depth cannot wrap the bound.
    localparam logic [32:0] SPAN  = 33'(4 * MEMORY_DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // ---------------------------------------------------------------------
    // State and captured request
    // ---------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;

    logic [31:0]             mem [MEMORY_DEPTH];

    // ---------------------------------------------------------------------
    // Current request view. In IDLE the live inputs are the request. Once
    // accepted, the captured copy is used, so later input changes are
    // ignored. With WAIT_STATES=0 the commit happens on the acceptance edge
    // itself, so the same mux feeds the datapath in both cases.
    // ---------------------------------------------------------------------
    logic                    in_idle;
    logic                    accept;
    logic [31:0]             cur_addr;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic [1:0]              cur_size;
    logic                    cur_uns;
    logic                    cur_write;

    assign in_idle   = (state_q == ST_IDLE);
    assign accept    = in_idle && (MemRead || MemWrite);
    assign cur_addr  = in_idle ? Address   : addr_q;
    assign cur_wdata = in_idle ? WriteData : wdata_q;
    assign cur_size  = in_idle ? Size      : size_q;
    assign cur_uns   = in_idle ? Unsigned  : uns_q;
    assign cur_write = in_idle ? MemWrite  : write_q;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [31:0]      offset;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             req_illegal;

    assign offset = cur_addr - BASE_ADDRESS;
    assign lane   = cur_addr[1:0];
    assign idx    = offset[IDX_W+1:2];

    // Only consumed in IDLE, where cur_* equals the live inputs.
    always_comb begin
        req_illegal = 1'b0;
        if (MemRead && MemWrite)                      req_illegal = 1'b1;
        if (cur_size == 2'b11)                        req_illegal = 1'b1;
        if (cur_size == SZ_HALF && cur_addr[0])       req_illegal = 1'b1;
        if (cur_size == SZ_WORD && lane != 2'b00)     req_illegal = 1'b1;
        if (cur_addr < BASE_ADDRESS)                  req_illegal = 1'b1;
        if ({1'b0, offset} >= SPAN)                   req_illegal = 1'b1;
    end

    // ---------------------------------------------------------------------
    // Control FSM: next state, wait counter, commit strobe
    // ---------------------------------------------------------------------
    logic commit;   // high in the cycle whose closing edge enters DONE legally

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_illegal) begin
                        state_d = ST_DONE;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                // The counter holds the WAIT cycles still to run, including this one.
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 3'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Request capture on acceptance.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        err_d   = err_q;
        if (accept) begin
            addr_d  = Address;
            wdata_d = WriteData;
            size_d  = Size;
            uns_d   = Unsigned;
            write_d = MemWrite;
            err_d   = req_illegal;
        end
    end

    // ---------------------------------------------------------------------
    // Store path: lane enables and replicated store data
    // ---------------------------------------------------------------------
    logic [3:0]  byte_en;
    logic [31:0] store_lanes;
    logic        mem_we;

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = cur_wdata;
        unique case (cur_size)
            SZ_BYTE: begin
                byte_en     = 4'b0001 << lane;
                store_lanes = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en     = cur_addr[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{cur_wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_en     = 4'b1111;
            end
            default: begin
                byte_en     = 4'b0000;
            end
        endcase
    end

    // The reset term blocks a write when reset is held low across a
    // zero-wait acceptance edge.
    assign mem_we = commit && cur_write && reset;

    // NOTE: the storage array has no reset. Its contents are undefined until
    // written, which lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= store_lanes[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Load path: lane extraction and extension
    // ---------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign rd_word  = mem[idx];
    assign half_sel = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        unique case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
    end

    always_comb begin
        unique case (cur_size)
            SZ_BYTE: load_val = {{24{~cur_uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{~cur_uns & half_sel[15]}}, half_sel};
            default: load_val = rd_word;
        endcase
    end

    // ReadData changes only on a legal load. Writes and errors leave it alone.
    always_comb begin
        read_data_d = read_data_q;
        if (commit && !cur_write) begin
            read_data_d = load_val;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            write_q     <= write_d;
            err_q       <= err_d;
            read_data_q <= read_data_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ReadData  = read_data_q;
    assign Ready     = (state_q == ST_DONE);
    assign AddrError = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// -----------------------------------------------------------------------------
// tb_byte_data_memory
//
// Self-checking bench for byte_data_memory (WAIT_STATES=1, defaults otherwise).
// A byte-level reference model in an associative array predicts load values,
// legality, latency and the held ReadData. Directed scenarios come first,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_byte_data_memory;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 1;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        Ready;
    logic        AddrError;

    byte_data_memory #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (DEPTH),
        .WAIT_STATES  (WS),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Size      (Size),
        .Unsigned  (Unsigned),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .AddrError (AddrError)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte contents keyed by offset from BASE, and the
    // value ReadData should currently hold.
    logic [7:0]  mref [int unsigned];
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_illegal(input bit rd, input bit wr,
                                       input logic [1:0] sz, input logic [31:0] a);
        longint unsigned off;
        if (rd && wr)                 return 1'b1;
        if (sz == 2'b11)              return 1'b1;
        if (sz == 2'b01 && a[0])      return 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        if (a < BASE)                 return 1'b1;
        off = longint'(a) - longint'(BASE);
        if (off >= 4 * DEPTH)         return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a);
        int unsigned nb;
        int unsigned off;
        logic [31:0] v;
        nb  = 1 << sz;
        off = a - BASE;
        v   = 32'h0;
        for (int i = 0; i < nb; i++) begin
            v = v | (32'(mref[off + i]) << (8 * i));
        end
        if (!uns && nb < 4 && v[8*nb-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int unsigned nb;
        int unsigned off;
        nb  = 1 << sz;
        off = a - BASE;
        for (int i = 0; i < nb; i++) begin
            mref[off + i] = wd[8*i +: 8];
        end
    endtask

    // One complete access. The inputs are scrambled while the access is in
    // flight, which must have no effect. The strobes are dropped in the
    // Ready cycle. The task checks latency, the error flag, ReadData and
    // the single-cycle Ready pulse.
    task automatic do_access(input string tag, input bit rd, input bit wr,
                             input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd);
        bit          exp_err;
        int          exp_lat;
        int          lat;
        bit          seen;
        logic        got_err;
        exp_err = ref_illegal(rd, wr, sz, a);
        exp_lat = exp_err ? 1 : WS + 1;

        @(negedge clk);
        Address   = a;
        WriteData = wd;
        Size      = sz;
        Unsigned  = uns;
        MemRead   = rd;
        MemWrite  = wr;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (Ready) begin
                seen = 1'b1;
                break;
            end
            Address   = $urandom;
            WriteData = $urandom;
            Size      = 2'($urandom);
            Unsigned  = 1'($urandom);
        end
        got_err = AddrError;
        check($sformatf("%s_ready", tag), 32'(seen), 32'd1);
        check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_err", tag), 32'(got_err), 32'(exp_err));

        if (!exp_err && wr) ref_store(sz, a, wd);
        if (!exp_err && rd) last_rd = ref_load(sz, uns, a);
        check($sformatf("%s_rdata", tag), ReadData, last_rd);

        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        check($sformatf("%s_pulse", tag), 32'(Ready), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Size      = 2'b00;
        Unsigned  = 1'b0;

        // Outputs must be forced while reset is low, before any clock edge.
        #3;
        check("rst_rdata", ReadData, 32'h0);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_err",   32'(AddrError), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Word store, then load it back.
        do_access("sw",  1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
        do_access("lw",  1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
        check("lw_const", ReadData, 32'hDEAD_BEEF);

        // Sub-word loads with both extension modes.
        do_access("lb",  1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0007, 32'h0);
        check("lb_const", ReadData, 32'hFFFF_FFDE);
        do_access("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h1001_0007, 32'h0);
        check("lbu_const", ReadData, 32'h0000_00DE);
        do_access("lh",  1'b1, 1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'h0);
        check("lh_const", ReadData, 32'hFFFF_DEAD);
        do_access("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0);
        check("lhu_const", ReadData, 32'h0000_DEAD);

        // A byte store touches a single lane.
        do_access("sb",  1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0005, 32'h1234_5655);
        do_access("lw2", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
        check("lw2_const", ReadData, 32'hDEAD_55EF);

        // Illegal accesses: misaligned and out of range.
        do_access("lw_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0);
        do_access("sh_mis", 1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'hFFFF_FFFF);
        do_access("sw_oob", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_1000, 32'hFFFF_FFFF);
        check("err_hold", ReadData, 32'hDEAD_55EF);
        do_access("lw3", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
        check("lw3_const", ReadData, 32'hDEAD_55EF);

        // Reset while the access is in WAIT abandons the store.
        @(negedge clk);
        Address   = 32'h1001_0004;
        WriteData = 32'h0;
        Size      = 2'b10;
        MemWrite  = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_rdata", ReadData, 32'h0);
        check("mid_rst_ready", 32'(Ready), 32'd0);
        check("mid_rst_err",   32'(AddrError), 32'd0);
        MemWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b1;
        last_rd = 32'h0;
        do_access("lw_post_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
        check("lw_post_rst_const", ReadData, 32'hDEAD_55EF);

        // Both strobes high together is an error and must not write.
        do_access("both", 1'b1, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h0000_0000);
        do_access("lw4", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
        check("lw4_const", ReadData, 32'hDEAD_55EF);

        // A strobe held past Ready is taken as a second request.
        begin
            int  k1;
            int  k2;
            bit  s1;
            bit  s2;
            @(negedge clk);
            Address  = 32'h1001_0004;
            Size     = 2'b10;
            Unsigned = 1'b0;
            MemRead  = 1'b1;
            k1 = 0; s1 = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                k1++;
                if (Ready) begin s1 = 1'b1; break; end
            end
            check("hold_first_ready", 32'(s1), 32'd1);
            check("hold_first_lat",   32'(k1), 32'(WS + 1));
            k2 = 0; s2 = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                k2++;
                if (Ready) begin s2 = 1'b1; break; end
            end
            MemRead = 1'b0;
            check("hold_second_ready", 32'(s2), 32'd1);
            check("hold_second_gap",   32'(k2), 32'(WS + 2));
            check("hold_second_rdata", ReadData, 32'hDEAD_55EF);
            @(negedge clk);
        end

        // Randomized traffic: fill a low region and the last word, then mix.
        for (int w = 0; w < 16; w++) begin
            do_access("fill", 1'b0, 1'b1, 2'b10, 1'b0, BASE + 32'(4 * w), $urandom);
        end
        do_access("fill_top", 1'b0, 1'b1, 2'b10, 1'b0, BASE + 32'(4 * DEPTH - 4), $urandom);

        for (int n = 0; n < 250; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            bit          rd;
            bit          wr;
            int          cls;
            int          kind;
            sz  = ($urandom_range(0, 99) < 5) ? 2'b11 : 2'($urandom_range(0, 2));
            cls = $urandom_range(0, 9);
            case (cls)
                0:       a = BASE - 32'($urandom_range(1, 16));
                1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
                2:       a = BASE + 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 3));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            kind = $urandom_range(0, 19);
            rd   = (kind == 0) ? 1'b1 : kind[0];
            wr   = (kind == 0) ? 1'b1 : ~kind[0];
            do_access($sformatf("rnd%0d", n), rd, wr, sz, 1'($urandom), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
